// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC unit: resolves branch/jump direction, owns the PC, runs a single-outstanding
// instruction-memory handshake and holds one fetched instruction for decode.
module fetch_redirect_unit #(
  parameter int unsigned           AWIDTH   = 32,
  parameter int unsigned           DWIDTH   = 32,
  parameter logic [AWIDTH-1:0]     BASEADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resolve_vld_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic [AWIDTH-1:0] target_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              insn_vld_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] insn_pc_o,
  input  logic              insn_rdy_i,
  output logic              redirect_o,
  output logic              misalign_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                kill_q, kill_d;
  logic                buf_vld_q, buf_vld_d;
  logic [DWIDTH-1:0]   buf_insn_q, buf_insn_d;
  logic [AWIDTH-1:0]   buf_pc_q, buf_pc_d;
  logic                misalign_q, misalign_d;

  logic                taken;
  logic [AWIDTH-1:0]   tgt_adj;
  logic [AWIDTH-1:0]   tgt_pc;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    taken = 1'b0;
    case (opcode_i)
      OP_BRANCH: begin
        case (funct3_i)
          3'b000:         taken = breq_i;
          3'b001:         taken = !breq_i;
          3'b100, 3'b110: taken = brlt_i;
          3'b101, 3'b111: taken = !brlt_i;
          default:        taken = 1'b0;
        endcase
      end
      OP_JAL, OP_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  assign tgt_adj    = (opcode_i == OP_JALR) ? {target_i[AWIDTH-1:1], 1'b0} : target_i;
  assign tgt_pc     = {tgt_adj[AWIDTH-1:2], 2'b00};
  assign redirect_o = resolve_vld_i & taken;

  // A new fetch may only start if its result will have somewhere to land.
  assign imem_req_o = (state_q == S_REQ) & (!buf_vld_q | insn_rdy_i);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    buf_vld_d     = buf_vld_q & !insn_rdy_i;
    buf_insn_d    = buf_insn_q;
    buf_pc_d      = buf_pc_q;
    misalign_d    = redirect_o & (tgt_adj[1:0] != 2'b00);

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_o && imem_gnt_i) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + AWIDTH'(4);
          kill_d        = redirect_o;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (!kill_q && !redirect_o) begin
            buf_vld_d  = 1'b1;
            buf_insn_d = imem_rdata_i;
            buf_pc_d   = inflight_pc_q;
          end
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else if (redirect_o) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides sequential increment and discards whatever decode has not yet used.
    if (redirect_o) begin
      pc_d      = tgt_pc;
      buf_vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= BASEADDR;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      buf_vld_q     <= 1'b0;
      // NOTE: the buffer payload is reset too, because the outputs it drives must read 0 in reset.
      buf_insn_q    <= '0;
      buf_pc_q      <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      buf_vld_q     <= buf_vld_d;
      buf_insn_q    <= buf_insn_d;
      buf_pc_q      <= buf_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign insn_vld_o  = buf_vld_q;
  assign insn_o      = buf_insn_q;
  assign insn_pc_o   = buf_pc_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: a transaction-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fetch_redirect_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [6:0]  OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic        clk = 1'b0, rst = 1'b1;
  logic        resolve_vld_i = 1'b0, breq_i = 1'b0, brlt_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] target_i = '0;
  logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        insn_vld_o, insn_rdy_i = 1'b1, redirect_o, misalign_o;
  logic [31:0] insn_o, insn_pc_o;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit dut (
    .clk(clk), .rst(rst),
    .resolve_vld_i(resolve_vld_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .breq_i(breq_i), .brlt_i(brlt_i), .target_i(target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .insn_vld_o(insn_vld_o), .insn_o(insn_o), .insn_pc_o(insn_pc_o), .insn_rdy_i(insn_rdy_i),
    .redirect_o(redirect_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] insn; } entry_t;

  entry_t      m_buf[$];
  logic [31:0] m_pc, m_flight_pc;
  bit          m_fresh, m_busy, m_dead, m_mis;

  function automatic bit m_taken(input logic [6:0] op, input logic [2:0] f3,
                                 input logic eq, input logic lt);
    if (op == OP_JAL || op == OP_JALR) return 1'b1;
    if (op != OP_BR || f3[2:1] == 2'b01) return 1'b0;
    return (f3[2] ? lt : eq) ^ f3[0];
  endfunction

  always @(negedge clk) begin
    bit          redir, want, eat, mis_now;
    logic [31:0] dest;
    entry_t      fresh_e;
    bit          push;
    if (rst) begin
      m_buf.delete();
      m_pc = BASE; m_flight_pc = '0;
      m_fresh = 1'b1; m_busy = 1'b0; m_dead = 1'b0; m_mis = 1'b0;
    end
    redir   = resolve_vld_i && m_taken(opcode_i, funct3_i, breq_i, brlt_i);
    dest    = target_i & 32'hFFFF_FFFC;
    mis_now = (opcode_i == OP_JALR) ? target_i[1] : (target_i[1:0] != 2'b00);
    want    = !m_fresh && !m_busy && (m_buf.size() == 0 || insn_rdy_i);
    eat     = (m_buf.size() != 0) && insn_rdy_i;

    check("mdl_redirect", {31'd0, redirect_o}, {31'd0, redir});
    check("mdl_req", {31'd0, imem_req_o}, {31'd0, want});
    check("mdl_addr", imem_addr_o, m_pc);
    check("mdl_vld", {31'd0, insn_vld_o}, {31'd0, m_buf.size() != 0});
    check("mdl_misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    if (m_buf.size() != 0) begin
      check("mdl_insn", insn_o, m_buf[0].insn);
      check("mdl_insn_pc", insn_pc_o, m_buf[0].pc);
    end

    if (!rst) begin
      push = 1'b0;
      fresh_e = '{pc: m_flight_pc, insn: imem_rdata_i};
      if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (!m_busy) begin
        if (want && imem_gnt_i) begin
          m_busy = 1'b1; m_dead = redir; m_flight_pc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (imem_rvalid_i) begin
        push   = !m_dead && !redir;
        m_busy = 1'b0; m_dead = 1'b0;
      end else if (redir) begin
        m_dead = 1'b1;
      end
      if (redir) m_pc = dest;
      if (eat) void'(m_buf.pop_front());
      if (redir) m_buf.delete();
      if (push) m_buf.push_back(fresh_e);
      m_mis = redir && mis_now;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic resolve(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                         input logic lt, input logic [31:0] tgt);
    resolve_vld_i = 1'b1; opcode_i = op; funct3_i = f3; breq_i = eq; brlt_i = lt; target_i = tgt;
  endtask

  // Apply memory/decode inputs, then stop at the negedge where outputs are observed.
  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd; insn_rdy_i = rdy;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    resolve_vld_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; insn_rdy_i = 1'b1;
  endtask

  typedef struct {
    logic       vld; logic [6:0] op; logic [2:0] f3; logic eq; logic lt; logic exp;
  } dec_t;

  dec_t dec_tab[12] = '{
    '{1'b1, OP_BR,      3'b000, 1'b1, 1'b0, 1'b1},  // BEQ equal
    '{1'b1, OP_BR,      3'b000, 1'b0, 1'b1, 1'b0},  // BEQ not equal
    '{1'b1, OP_BR,      3'b001, 1'b1, 1'b0, 1'b0},  // BNE equal
    '{1'b1, OP_BR,      3'b100, 1'b0, 1'b0, 1'b0},  // BLT not less
    '{1'b1, OP_BR,      3'b101, 1'b0, 1'b0, 1'b1},  // BGE not less
    '{1'b1, OP_BR,      3'b111, 1'b0, 1'b0, 1'b1},  // BGEU not less
    '{1'b1, OP_BR,      3'b110, 1'b0, 1'b1, 1'b1},  // BLTU less
    '{1'b1, OP_BR,      3'b010, 1'b1, 1'b1, 1'b0},  // reserved funct3
    '{1'b1, OP_BR,      3'b011, 1'b0, 1'b0, 1'b0},  // reserved funct3
    '{1'b1, 7'b0110011, 3'b000, 1'b1, 1'b1, 1'b0},  // non-branch opcode
    '{1'b0, OP_JAL,     3'b000, 1'b0, 1'b0, 1'b0},  // JAL without resolve valid
    '{1'b1, OP_JAL,     3'b000, 1'b0, 1'b0, 1'b1}   // JAL
  };

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0100_0000);
    check("rst_vld", {31'd0, insn_vld_o}, 32'd0);
    check("rst_insn", insn_o, 32'd0);
    check("rst_insn_pc", insn_pc_o, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // First fetch after reset
    drive(1, 0, 0, 1);  check("idle_req", {31'd0, imem_req_o}, 32'd0); nxt();
    drive(1, 0, 0, 1);  check("first_req", {31'd0, imem_req_o}, 32'd1);
                        check("first_addr", imem_addr_o, 32'h0100_0000); nxt();
    drive(0, 1, 32'h0000_0013, 1);
                        check("next_addr", imem_addr_o, 32'h0100_0004); nxt();
    drive(0, 0, 0, 0);  check("first_vld", {31'd0, insn_vld_o}, 32'd1);
                        check("first_insn", insn_o, 32'h0000_0013);
                        check("first_pc", insn_pc_o, 32'h0100_0000);
                        check("full_no_req", {31'd0, imem_req_o}, 32'd0); nxt();

    // BNE taken flushes the held instruction
    resolve(OP_BR, 3'b001, 1'b0, 1'b0, 32'h0100_0040);
    drive(0, 0, 0, 0);  check("bne_redirect", {31'd0, redirect_o}, 32'd1); nxt();
    // BGEU with brlt=1 is not taken, PC increments
    resolve(OP_BR, 3'b111, 1'b0, 1'b1, 32'h0100_0999);
    drive(1, 0, 0, 1);  check("bgeu_redirect", {31'd0, redirect_o}, 32'd0);
                        check("bne_addr", imem_addr_o, 32'h0100_0040);
                        check("bne_flushed", {31'd0, insn_vld_o}, 32'd0); nxt();
    // BLT with brlt=1 redirects while the fetch is outstanding
    resolve(OP_BR, 3'b100, 1'b0, 1'b1, 32'h0100_0080);
    drive(0, 0, 0, 1);  check("blt_redirect", {31'd0, redirect_o}, 32'd1);
                        check("bgeu_addr", imem_addr_o, 32'h0100_0044); nxt();
    drive(0, 0, 0, 1);  nxt();
    drive(0, 0, 0, 1);  nxt();
    drive(0, 1, 32'hDEAD_BEEF, 1);
                        check("wait_addr", imem_addr_o, 32'h0100_0080); nxt();
    drive(1, 0, 0, 1);  check("killed_vld", {31'd0, insn_vld_o}, 32'd0);
                        check("killed_req", {31'd0, imem_req_o}, 32'd1);
                        check("killed_addr", imem_addr_o, 32'h0100_0080); nxt();

    // JALR redirect coinciding with the response: data dropped, misaligned target
    resolve(OP_JALR, 3'b000, 1'b0, 1'b0, 32'h0100_0102);
    drive(0, 1, 32'h0010_0093, 1);
                        check("jalr_redirect", {31'd0, redirect_o}, 32'd1); nxt();
    resolve(OP_JALR, 3'b000, 1'b0, 1'b0, 32'h0100_0103);
    drive(0, 0, 0, 1);  check("jalr_mis1", {31'd0, misalign_o}, 32'd1);
                        check("jalr_drop", {31'd0, insn_vld_o}, 32'd0);
                        check("jalr_addr1", imem_addr_o, 32'h0100_0100); nxt();
    drive(1, 0, 0, 1);  check("jalr_mis2", {31'd0, misalign_o}, 32'd1);
                        check("jalr_addr2", imem_addr_o, 32'h0100_0100); nxt();
    drive(0, 1, 32'hAAAA_0001, 0);
                        check("mis_pulse_end", {31'd0, misalign_o}, 32'd0); nxt();

    // Decode stalls for 5 cycles: buffer holds and no new request goes out
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      check("stall_vld", {31'd0, insn_vld_o}, 32'd1);
      check("stall_insn", insn_o, 32'hAAAA_0001);
      check("stall_pc", insn_pc_o, 32'h0100_0100);
      check("stall_req", {31'd0, imem_req_o}, 32'd0);
      nxt();
    end

    // PC wrap at the top of the address space
    resolve(OP_JAL, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1);  check("jal_redirect", {31'd0, redirect_o}, 32'd1); nxt();
    drive(1, 0, 0, 1);  check("top_addr", imem_addr_o, 32'hFFFF_FFFC);
                        check("top_req", {31'd0, imem_req_o}, 32'd1); nxt();
    drive(0, 1, 32'h0000_006F, 1);
                        check("wrap_addr", imem_addr_o, 32'h0000_0000); nxt();
    drive(0, 0, 0, 1);  check("wrap_vld", {31'd0, insn_vld_o}, 32'd1);
                        check("wrap_pc", insn_pc_o, 32'hFFFF_FFFC);
                        check("wrap_insn", insn_o, 32'h0000_006F); nxt();

    // Taken/not-taken decode table
    foreach (dec_tab[i]) begin
      resolve(dec_tab[i].op, dec_tab[i].f3, dec_tab[i].eq, dec_tab[i].lt, 32'h0100_0200);
      resolve_vld_i = dec_tab[i].vld;
      drive(0, 0, 0, 1);
      check($sformatf("decode_%0d", i), {31'd0, redirect_o}, {31'd0, dec_tab[i].exp});
      nxt();
    end

    // Reset in the middle of a fetch; a late response is ignored
    drive(1, 0, 0, 1);  check("pre_rst_addr", imem_addr_o, 32'h0100_0200); nxt();
    #2 rst = 1'b1;
    #1 check("mid_rst_addr", imem_addr_o, 32'h0100_0000);
    check("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1, 32'h1234_5678, 1);
                        check("post_rst_idle", {31'd0, imem_req_o}, 32'd0); nxt();
    drive(0, 0, 0, 1);  check("post_rst_vld", {31'd0, insn_vld_o}, 32'd0);
                        check("post_rst_req", {31'd0, imem_req_o}, 32'd1);
                        check("post_rst_addr", imem_addr_o, 32'h0100_0000); nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
